dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Initiator-side controller between the pipeline MEM stage and the word-addressed data memory. It accepts one read or write per request, range- and alignment-checks the byte address, and drives the memory strobes with a configurable wait-state count. It freezes the pipeline with `stall` until the access completes and returns read data with a one-cycle `rd_valid` pulse.

## Interface
- `WAIT_CYCLES`, default 2: memory access cycles per transfer; legal range 1..15.
- `BASE_ADDR`, default 1024: byte address of memory word 0.
- `DEPTH_WORDS`, default 64: number of 32-bit words in the data memory.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_rd` in 1: read request from the MEM stage. Held stable while `stall`=1.
- `req_wr` in 1: write request. Held stable while `stall`=1.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: write data.
- `stall` out 1: freezes the pipeline.
- `rd_data` out 32: registered read result.
- `rd_valid` out 1: one-cycle pulse when a read completes.
- `err` out 1: one-cycle pulse for an illegal request.
- `mem_r_en` out 1: memory read strobe.
- `mem_w_en` out 1: memory write strobe. The memory samples it on a rising edge.
- `mem_addr` out 32: byte address to the memory, passed through unmodified.
- `mem_wdata` out 32: write data to the memory.
- `mem_rdata` in 32: memory read data. Combinational and valid while `mem_r_en`=1.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE
  - On `req_rd` or `req_wr`: latch the address and data.
  - Go to ACCESS if the request is legal.
  - Go to DONE with the error flag set if the request is illegal.
- Illegal request, any of:
  - `req_addr[1:0]`≠0.
  - `req_addr` < BASE_ADDR.
  - `req_addr` ≥ BASE_ADDR+4·DEPTH_WORDS, compared as 32-bit unsigned.
  - `req_rd` and `req_wr` asserted together.
- ACCESS
  - A 4-bit counter counts WAIT_CYCLES cycles.
  - Read: `mem_r_en`=1 for the whole ACCESS phase. `mem_rdata` is captured into `rd_data` on the last cycle.
  - Write: `mem_w_en`=1 only on the last ACCESS cycle, so exactly one memory write per request.
  - On the last cycle, go to DONE.
- DONE
  - `stall`=0 so the pipeline advances.
  - `rd_valid`=1 for a read.
  - `err`=1 if the request was illegal; `rd_data` is then forced to 0.
  - Go to IDLE unconditionally.
- `stall` = (`req_rd`|`req_wr`) & (state≠DONE); it is combinational.
- `mem_addr` and `mem_wdata` come from the latched registers, not the live pipeline inputs.
- No memory strobe is ever asserted in IDLE or DONE.

## Timing
- Legal access, request first seen at cycle 0:
  - ACCESS occupies cycles 1..WAIT_CYCLES.
  - DONE is cycle WAIT_CYCLES+1.
  - `stall` is high for WAIT_CYCLES+1 cycles.
- Illegal access: `stall` high for 1 cycle; DONE at cycle 1.
- Back-to-back requests: one IDLE cycle between DONE and the next ACCESS.
- Reset values: state IDLE, counter 0, `rd_data`=0, `rd_valid`=0, `err`=0, `mem_r_en`=0, `mem_w_en`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-ACCESS aborts the transfer. No write strobe is issued after reset deasserts; the pipeline must re-present the request.
- If the request drops while in ACCESS (protocol violation), the FSM still completes; completion cannot be cancelled.

## Configuration
- `DMEM_WBUF_EN` defined: adds a one-entry posted write buffer.
  - A legal write in IDLE with the buffer empty is accepted with `stall`=0 that cycle.
  - The buffer drains through ACCESS in the background.
  - A write arriving while the buffer is full stalls until the drain completes.
  - A read to a different address during a drain stalls until the drain finishes, then runs its own ACCESS.
  - A read whose address matches the buffered address returns the buffered data via IDLE→DONE, with 1 stall cycle and no memory strobe.
- `DMEM_WBUF_EN` undefined: writes behave exactly as reads (blocking), and no buffer logic is synthesised.

## Structure
- Package `dmem_ctrl_pkg` contains:
  - the state enum (IDLE/ACCESS/DONE);
  - default constants `DMEM_BASE_ADDR`=1024 and `DMEM_DEPTH_WORDS`=64;
  - the address-legality function.
- Sub-module `dmem_wbuf` holds the buffer entry:
  - valid, address and data registers;
  - the address-match compare;
  - instantiated only under `DMEM_WBUF_EN`.

## Test plan
- Read, WAIT_CYCLES=2, addr 1032, memory word 2 = 0xDEADBEEF → `stall` high for 3 cycles; `rd_valid` plus `rd_data`=0xDEADBEEF in the 4th cycle; `mem_w_en` never asserted.
- Write 0x12345678 to 1028 → `mem_w_en` high for exactly 1 cycle, on cycle 2; a following read of 1028 returns 0x12345678.
- Misaligned addr 1026, and addr 1280 → no strobes; `err` pulse at cycle 1; `stall` high for 1 cycle; `rd_data`=0.
- `req_rd` and `req_wr` asserted together at addr 1024 → `err` pulse; no memory strobe.
- `rst` pulsed on cycle 1 of a write → no `mem_w_en` pulse after reset; all outputs at reset values.
- `DMEM_WBUF_EN`: write 0xA5A5A5A5 to 1040, then an immediate read of 1040 → write takes 0 stall cycles; read returns 0xA5A5A5A5 after 1 stall cycle; memory is written exactly once.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types, default geometry and the address-legality check for the data-memory access controller.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [31:0] DMEM_BASE_ADDR   = 32'd1024;
  localparam int unsigned DMEM_DEPTH_WORDS = 64;

  // Word-aligned and inside [base, base + 4*depth), all in 32-bit unsigned arithmetic.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
    logic [31:0] limit;
    limit = base + (depth << 2);
    return (addr[1:0] == 2'b00) && (addr >= base) && (addr < limit);
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// MEM-stage request bus plus data-memory strobe bus of the access controller.
interface dmem_access_ctrl_if;
  // Handshake: the MEM stage raises req_rd/req_wr with address/data and holds all
  // of them stable while stall=1; the request is consumed on the first rising edge
  // at which stall=0. rd_valid and err are single-cycle result pulses.
  logic        req_rd;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        err;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_rd, req_wr, req_addr, req_wdata, mem_rdata,
    input  stall, rd_data, rd_valid, err, mem_r_en, mem_w_en, mem_addr, mem_wdata
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, mem_rdata,
    output stall, rd_data, rd_valid, err, mem_r_en, mem_w_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer (valid/address/data) with an address-match probe.
// Only built when DMEM_WBUF_EN is defined.
`ifdef DMEM_WBUF_EN
module dmem_wbuf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic [31:0] probe_addr,
  output logic        valid,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        match
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= 32'h0;
      data  <= 32'h0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign match = valid && (addr == probe_addr);

endmodule
`endif

// File: rtl/dmem_access_ctrl.sv
// MEM-stage to data-memory access controller: legality check, wait-stated strobes, stall and read return.
// Optional posted write buffer enabled by defining DMEM_WBUF_EN.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  dmem_access_ctrl_if.slave  bus,
  output state_t             state_dbg
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic        op_drain;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;
  logic        err_q;
  logic        mem_r_en_q;
  logic        mem_w_en_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic req_any;
  logic req_legal;
  logic last_cyc;

  assign req_any   = bus.req_rd | bus.req_wr;
  assign req_legal = addr_legal(bus.req_addr, BASE_ADDR, 32'(DEPTH_WORDS))
                     & ~(bus.req_rd & bus.req_wr);
  assign last_cyc  = (cnt == LAST_CNT);

`ifdef DMEM_WBUF_EN
  logic        buf_valid;
  logic        buf_match;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;
  logic        wr_accept;
  logic        rd_hit;
  logic        buf_clear;

  assign wr_accept = (state == IDLE) & bus.req_wr & ~bus.req_rd & req_legal & ~buf_valid;
  assign rd_hit    = (state == IDLE) & bus.req_rd & ~bus.req_wr & req_legal & buf_match;
  assign buf_clear = (state == ACCESS) & op_drain & last_cyc;

  dmem_wbuf u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .load       (wr_accept),
    .clear      (buf_clear),
    .load_addr  (bus.req_addr),
    .load_data  (bus.req_wdata),
    .probe_addr (bus.req_addr),
    .valid      (buf_valid),
    .addr       (buf_addr),
    .data       (buf_data),
    .match      (buf_match)
  );

  // A posted write is consumed in the same cycle, so it must not freeze the pipeline.
  assign bus.stall = req_any & (state != DONE) & ~wr_accept;
`else
  assign bus.stall = req_any & (state != DONE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      op_wr       <= 1'b0;
      op_drain    <= 1'b0;
      rd_data_q   <= 32'h0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      mem_r_en_q  <= 1'b0;
      mem_w_en_q  <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any && !req_legal) begin
            state       <= DONE;
            err_q       <= 1'b1;
            rd_data_q   <= 32'h0;
            op_wr       <= bus.req_wr;
            op_drain    <= 1'b0;
            mem_addr_q  <= bus.req_addr;
            mem_wdata_q <= bus.req_wdata;
`ifdef DMEM_WBUF_EN
          end else if (rd_hit) begin
            state      <= DONE;
            rd_data_q  <= buf_data;
            rd_valid_q <= 1'b1;
            op_wr      <= 1'b0;
            op_drain   <= 1'b0;
          end else if (buf_valid) begin
            // Drain before serving anything that cannot bypass the buffer.
            state       <= ACCESS;
            cnt         <= 4'd1;
            op_wr       <= 1'b1;
            op_drain    <= 1'b1;
            mem_addr_q  <= buf_addr;
            mem_wdata_q <= buf_data;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= (LAST_CNT == 4'd1);
          end else if (req_any && !wr_accept) begin
`else
          end else if (req_any) begin
`endif
            state       <= ACCESS;
            cnt         <= 4'd1;
            op_wr       <= bus.req_wr;
            op_drain    <= 1'b0;
            mem_addr_q  <= bus.req_addr;
            mem_wdata_q <= bus.req_wdata;
            mem_r_en_q  <= bus.req_rd;
            mem_w_en_q  <= bus.req_wr && (LAST_CNT == 4'd1);
          end
        end
        ACCESS: begin
          if (last_cyc) begin
            cnt        <= 4'd0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            if (!op_wr) begin
              rd_data_q  <= bus.mem_rdata;
              rd_valid_q <= 1'b1;
            end
            // A background drain has no pipeline consumer, so it skips DONE.
            state <= op_drain ? IDLE : DONE;
          end else begin
            cnt        <= cnt + 4'd1;
            mem_w_en_q <= op_wr && ((cnt + 4'd1) == LAST_CNT);
          end
        end
        DONE: begin
          state    <= IDLE;
          op_drain <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.err       = err_q;
  assign bus.mem_r_en  = mem_r_en_q;
  assign bus.mem_w_en  = mem_w_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl (WAIT_CYCLES=2, base 1024, 64 words) with a behavioural memory.
module tb_dmem_access_ctrl;
  import dmem_ctrl_pkg::*;

  typedef struct packed {
    int          stall_cycles;
    int          done_cycle;
    int          r_en_cycles;
    int          w_en_cycles;
    int          w_en_cycle;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        rd_valid;
    logic        err;
    logic [31:0] rd_data;
    logic        strobe_at_done;
    state_t      st_c1;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_access_ctrl_if bus ();
  state_t state_dbg;

  dmem_access_ctrl #(
    .WAIT_CYCLES (2),
    .BASE_ADDR   (32'd1024),
    .DEPTH_WORDS (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:63];
  int          mem_writes = 0;
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = 6'd0;
  logic [31:0] poke_data = 32'h0;
  logic [5:0]  mem_idx;

  assign mem_idx       = bus.mem_addr[7:2];
  assign bus.mem_rdata = bus.mem_r_en ? mem[mem_idx] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_w_en) begin
      mem[mem_idx] <= bus.mem_wdata;
      mem_writes   <= mem_writes + 1;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_data;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    poke_en   = 1'b1;
    poke_idx  = idx;
    poke_data = data;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Presents one request at cycle 0 (called just after a rising edge) and holds it
  // until the first cycle with stall=0; returns #1 after the edge that consumes it.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output obs_t o);
    logic done;
    o = '0;
    done = 1'b0;
    bus.req_rd    = rd;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 1) o.st_c1 = state_dbg;
      if (bus.mem_r_en) o.r_en_cycles++;
      if (bus.mem_w_en) begin
        o.w_en_cycles++;
        o.w_en_cycle = c;
        o.w_addr     = bus.mem_addr;
        o.w_data     = bus.mem_wdata;
      end
      if (bus.stall) begin
        o.stall_cycles++;
      end else begin
        o.done_cycle     = c;
        o.rd_valid       = bus.rd_valid;
        o.err            = bus.err;
        o.rd_data        = bus.rd_data;
        o.strobe_at_done = bus.mem_r_en | bus.mem_w_en;
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("timeout_stall_release", 32'(done), 32'd1);
    if (o.rd_valid) begin
      if (exp_q.size() > 0) check("rd_data_scoreboard", o.rd_data, exp_q.pop_front());
      else check("unexpected_rd_valid", 32'(o.rd_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
  endtask

  task automatic post_check(input string tag);
    @(negedge clk);
    check({tag, "_rd_valid_off"}, 32'(bus.rd_valid), 32'd0);
    check({tag, "_err_off"}, 32'(bus.err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  obs_t        o;
  int          wr_before;
  logic [31:0] bad_addr [4];
  logic        bad_rd   [4];
  logic        bad_wr   [4];

  initial begin
    bad_addr = '{32'd1026, 32'd1280, 32'd1020, 32'd1024};
    bad_rd   = '{1'b1, 1'b1, 1'b1, 1'b1};
    bad_wr   = '{1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    poke(6'd2, 32'hDEADBEEF);
    poke(6'd3, 32'h0BADF00D);
    poke(6'd63, 32'hCAFEF00D);

    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_mem_r_en", 32'(bus.mem_r_en), 32'd0);
    check("rst_mem_w_en", 32'(bus.mem_w_en), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Read word 2
    exp_q.push_back(32'hDEADBEEF);
    run_req(1'b1, 1'b0, 32'd1032, 32'h0, o);
    check("rd_stall_cycles", 32'(o.stall_cycles), 32'd3);
    check("rd_done_cycle", 32'(o.done_cycle), 32'd3);
    check("rd_valid_at_done", 32'(o.rd_valid), 32'd1);
    check("rd_r_en_cycles", 32'(o.r_en_cycles), 32'd2);
    check("rd_w_en_cycles", 32'(o.w_en_cycles), 32'd0);
    check("rd_state_c1", 32'(o.st_c1), 32'(ACCESS));
    check("rd_no_strobe_in_done", 32'(o.strobe_at_done), 32'd0);
    post_check("rd");

    // Write then immediate read-back of 1028
    wr_before = mem_writes;
    run_req(1'b0, 1'b1, 32'd1028, 32'h12345678, o);
`ifdef DMEM_WBUF_EN
    check("wr_posted_stall", 32'(o.stall_cycles), 32'd0);
`else
    check("wr_stall_cycles", 32'(o.stall_cycles), 32'd3);
    check("wr_w_en_cycles", 32'(o.w_en_cycles), 32'd1);
    check("wr_w_en_cycle", 32'(o.w_en_cycle), 32'd2);
    check("wr_mem_addr", o.w_addr, 32'd1028);
    check("wr_mem_wdata", o.w_data, 32'h12345678);
    check("wr_r_en_cycles", 32'(o.r_en_cycles), 32'd0);
    check("wr_rd_valid", 32'(o.rd_valid), 32'd0);
    check("wr_err", 32'(o.err), 32'd0);
`endif
    exp_q.push_back(32'h12345678);
    run_req(1'b1, 1'b0, 32'd1028, 32'h0, o);
    check("rdback_valid", 32'(o.rd_valid), 32'd1);

    // Last legal word
    exp_q.push_back(32'hCAFEF00D);
    run_req(1'b1, 1'b0, 32'd1276, 32'h0, o);
    check("rd_last_word_valid", 32'(o.rd_valid), 32'd1);
    check("rd_last_word_err", 32'(o.err), 32'd0);
    post_check("last_word");
    check("wr_exactly_once", 32'(mem_writes - wr_before), 32'd1);

    // Illegal requests: misaligned, at limit, below base, read+write together
    for (int i = 0; i < 4; i++) begin
      run_req(bad_rd[i], bad_wr[i], bad_addr[i], 32'hFFFF0000, o);
      check($sformatf("bad%0d_stall", i), 32'(o.stall_cycles), 32'd1);
      check($sformatf("bad%0d_done_cycle", i), 32'(o.done_cycle), 32'd1);
      check($sformatf("bad%0d_err", i), 32'(o.err), 32'd1);
      check($sformatf("bad%0d_rd_data", i), o.rd_data, 32'h0);
      check($sformatf("bad%0d_rd_valid", i), 32'(o.rd_valid), 32'd0);
      check($sformatf("bad%0d_r_en", i), 32'(o.r_en_cycles), 32'd0);
      check($sformatf("bad%0d_w_en", i), 32'(o.w_en_cycles), 32'd0);
      check($sformatf("bad%0d_state_c1", i), 32'(o.st_c1), 32'(DONE));
      post_check($sformatf("bad%0d", i));
    end

`ifdef DMEM_WBUF_EN
    // Posted write followed immediately by a read of the same address
    wr_before = mem_writes;
    run_req(1'b0, 1'b1, 32'd1040, 32'hA5A5A5A5, o);
    check("wbuf_wr_stall", 32'(o.stall_cycles), 32'd0);
    exp_q.push_back(32'hA5A5A5A5);
    run_req(1'b1, 1'b0, 32'd1040, 32'h0, o);
    check("wbuf_rd_stall", 32'(o.stall_cycles), 32'd1);
    check("wbuf_rd_valid", 32'(o.rd_valid), 32'd1);
    check("wbuf_rd_r_en", 32'(o.r_en_cycles), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("wbuf_single_write", 32'(mem_writes - wr_before), 32'd1);
    check("wbuf_mem_content", mem[4], 32'hA5A5A5A5);
`endif

    // Reset during cycle 1 of a write aborts it
    wr_before = mem_writes;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 32'd1036;
    bus.req_wdata = 32'h55AA55AA;
    @(posedge clk);
    #2 rst = 1'b1;
    bus.req_wr = 1'b0;
    @(negedge clk);
    check("rstmid_state", 32'(state_dbg), 32'(IDLE));
    check("rstmid_w_en", 32'(bus.mem_w_en), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rstmid_no_write", 32'(mem_writes - wr_before), 32'd0);
    check("rstmid_mem_unchanged", mem[3], 32'h0BADF00D);
    check("rstmid_mem_addr", bus.mem_addr, 32'h0);
    check("rstmid_mem_wdata", bus.mem_wdata, 32'h0);
    check("rstmid_rd_data", bus.rd_data, 32'h0);
    check("rstmid_r_en", 32'(bus.mem_r_en), 32'd0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
